// File: rtl/idecode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU op codes, immediate formats, pipeline record.
// Used by idecode (optional M extension enabled with IDECODE_MEXT_EN).
package idecode_pkg;
  localparam int ADDR = 16;
  localparam int WORD = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD      = 5'd0;
  localparam logic [4:0] ALU_SUB      = 5'd1;
  localparam logic [4:0] ALU_SLL      = 5'd2;
  localparam logic [4:0] ALU_SLT      = 5'd3;
  localparam logic [4:0] ALU_SLTU     = 5'd4;
  localparam logic [4:0] ALU_XOR      = 5'd5;
  localparam logic [4:0] ALU_SRL      = 5'd6;
  localparam logic [4:0] ALU_SRA      = 5'd7;
  localparam logic [4:0] ALU_OR       = 5'd8;
  localparam logic [4:0] ALU_AND      = 5'd9;
  localparam logic [4:0] ALU_PASS_IMM = 5'd10;
  localparam logic [4:0] ALU_MUL      = 5'd16;  // MUL group is ALU_MUL + funct3 (16..23)

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
  typedef enum logic {S_IDLE = 1'b0, S_BUBBLE = 1'b1} hz_state_e;

  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [WORD-1:0] imm;
    logic [4:0]      alu_op;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            illegal;
  } dec_t;

  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic sub, input logic sra);
    logic [4:0] op;
    case (f3)
      3'd0:    op = sub ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = sra ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction
endpackage

// File: rtl/idecode_immgen.sv
// Combinational RV32I immediate generator: sign-extends the I/S/B/U/J layouts to WORD bits.
module idecode_immgen
  import idecode_pkg::*;
(
  input  logic [WORD-1:7] inst_i,
  input  logic [2:0]      fmt_i,
  output logic [WORD-1:0] imm_o
);
  always_comb begin
    imm_o = '0;
    case (fmt_e'(fmt_i))
      FMT_I:   imm_o = {{21{inst_i[31]}}, inst_i[30:20]};
      FMT_S:   imm_o = {{21{inst_i[31]}}, inst_i[30:25], inst_i[11:7]};
      FMT_B:   imm_o = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      FMT_U:   imm_o = {inst_i[31:12], 12'b0};
      FMT_J:   imm_o = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end
endmodule

// File: rtl/idecode.sv
// RV32I decode stage with one output pipeline register and load-use hazard bubbling.
// Define IDECODE_MEXT_EN to decode the M-extension multiply/divide group.
module idecode
  import idecode_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] pc_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            v_o,
  output logic [ADDR-1:0] pc_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [WORD-1:0] imm_o,
  output logic [4:0]      alu_op_o,
  output logic            is_load_o,
  output logic            is_store_o,
  output logic            is_branch_o,
  output logic            is_jump_o,
  output logic            illegal_o
);
  // Handshake: inst_i is taken on a clock edge only when stall_o is low; while stall_o is
  // high ifetch must hold v_i/inst_i/pc_i stable. v_o qualifies every decoded field.
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  fmt_e       fmt;
  logic       legal, use_rd, use_rs1, use_rs2;
  logic       is_load, is_store, is_branch, is_jump;
  logic [4:0] alu_op;
  logic [WORD-1:0] imm;
  dec_t       dec_d, dec_q;
  logic       v_q, hazard;
  hz_state_e  state_d, state_q;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];

  idecode_immgen u_immgen (.inst_i(inst_i[WORD-1:7]), .fmt_i(fmt), .imm_o(imm));

  always_comb begin
    fmt = FMT_R; legal = 1'b1; alu_op = ALU_ADD;
    use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0; is_jump = 1'b0;
    case (opcode)
      OPC_LOAD:   begin fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; is_load = 1'b1;
                        legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7); end
      OPC_STORE:  begin fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1;
                        legal = (f3 <= 3'd2); end
      OPC_BRANCH: begin fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1; is_branch = 1'b1;
                        alu_op = ALU_SUB; legal = (f3 != 3'd2) && (f3 != 3'd3); end
      OPC_JAL:    begin fmt = FMT_J; use_rd = 1'b1; is_jump = 1'b1; end
      OPC_JALR:   begin fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; is_jump = 1'b1; end
      OPC_LUI:    begin fmt = FMT_U; use_rd = 1'b1; alu_op = ALU_PASS_IMM; end
      OPC_AUIPC:  begin fmt = FMT_U; use_rd = 1'b1; end
      OPC_OP_IMM: begin fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
                        alu_op = alu_from_f3(f3, 1'b0, inst_i[30]); end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        if (f7 == 7'b0000000) alu_op = alu_from_f3(f3, 1'b0, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) alu_op = alu_from_f3(f3, 1'b1, 1'b1);
`ifdef IDECODE_MEXT_EN
        else if (f7 == 7'b0000001) alu_op = ALU_MUL | {2'b00, f3};
`endif
        else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  // Unused register fields are forced to 0; an illegal slot carries only the illegal flag.
  always_comb begin
    dec_d = '0;
    dec_d.pc = pc_i;
    if (legal) begin
      dec_d.rd        = use_rd  ? inst_i[11:7]  : 5'd0;
      dec_d.rs1       = use_rs1 ? inst_i[19:15] : 5'd0;
      dec_d.rs2       = use_rs2 ? inst_i[24:20] : 5'd0;
      dec_d.imm       = imm;
      dec_d.alu_op    = alu_op;
      dec_d.is_load   = is_load;
      dec_d.is_store  = is_store;
      dec_d.is_branch = is_branch;
      dec_d.is_jump   = is_jump;
    end else begin
      dec_d.illegal   = 1'b1;
    end
  end

  // rd_q != 0 guarantees the zeroed (unused) source fields never match.
  always_comb begin
    hazard = (state_q == S_IDLE) && v_q && dec_q.is_load && (dec_q.rd != 5'd0) && v_i &&
             ((dec_d.rs1 == dec_q.rd) || (dec_d.rs2 == dec_q.rd));
    stall_o = stall_i | (hazard & ~flush_i);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (hazard && !stall_i && !flush_i) state_d = S_BUBBLE;
      S_BUBBLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      v_q     <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      if (flush_i || (!stall_i && hazard)) begin
        v_q   <= 1'b0;
        dec_q <= '0;
      end else if (!stall_i) begin
        v_q   <= v_i;
        dec_q <= dec_d;
      end
    end
  end

  assign v_o         = v_q;
  assign pc_o        = dec_q.pc;
  assign rd_o        = dec_q.rd;
  assign rs1_o       = dec_q.rs1;
  assign rs2_o       = dec_q.rs2;
  assign imm_o       = dec_q.imm;
  assign alu_op_o    = dec_q.alu_op;
  assign is_load_o   = dec_q.is_load;
  assign is_store_o  = dec_q.is_store;
  assign is_branch_o = dec_q.is_branch;
  assign is_jump_o   = dec_q.is_jump;
  assign illegal_o   = dec_q.illegal;
endmodule

// File: tb/tb_idecode.sv
// Bench for idecode: directed vector table, async-reset sequences, and random stimulus
// against a field-level RV32I reference model (IDECODE_MEXT_EN selects the M-extension model).
module tb_idecode;
  logic        clk = 1'b0;
  logic        rst, v_i, stall_i, flush_i;
  logic [31:0] inst_i;
  logic [15:0] pc_i;
  logic        stall_o, v_o;
  logic [15:0] pc_o;
  logic [4:0]  rd_o, rs1_o, rs2_o, alu_op_o;
  logic [31:0] imm_o;
  logic        is_load_o, is_store_o, is_branch_o, is_jump_o, illegal_o;

  idecode dut (
    .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o), .v_o(v_o), .pc_o(pc_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o), .alu_op_o(alu_op_o),
    .is_load_o(is_load_o), .is_store_o(is_store_o), .is_branch_o(is_branch_o),
    .is_jump_o(is_jump_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v; logic [4:0] rd, rs1, rs2; logic [31:0] imm; logic [4:0] alu;
    logic ld, st, br, jp, ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst; logic v, stall, flush, so; exp_t e;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input exp_t e, input logic [15:0] epc, input bit dopc, input string tag);
    chk({tag, " v_o"}, v_o, e.v);
    if (e.v) begin
      chk({tag, " illegal_o"}, illegal_o, e.ill);
      chk({tag, " rd_o"}, rd_o, e.rd);
      chk({tag, " rs1_o"}, rs1_o, e.rs1);
      chk({tag, " rs2_o"}, rs2_o, e.rs2);
      chk({tag, " flags"}, {is_load_o, is_store_o, is_branch_o, is_jump_o}, {e.ld, e.st, e.br, e.jp});
      if (!e.ill) begin
        chk({tag, " imm_o"}, imm_o, e.imm);
        chk({tag, " alu_op_o"}, alu_op_o, e.alu);
      end
      if (dopc) chk({tag, " pc_o"}, pc_o, epc);
    end
  endtask

  function automatic exp_t ex(input logic v, input int rd, input int rs1, input int rs2,
                              input logic [31:0] imm, input int alu, input logic ld,
                              input logic st, input logic br, input logic jp, input logic ill);
    exp_t e;
    e.v = v; e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2); e.imm = imm; e.alu = 5'(alu);
    e.ld = ld; e.st = st; e.br = br; e.jp = jp; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t vc(input logic [31:0] inst, input logic v, input logic stall,
                              input logic flush, input logic so, input exp_t e);
    vec_t r;
    r.inst = inst; r.v = v; r.stall = stall; r.flush = flush; r.so = so; r.e = e;
    return r;
  endfunction

  // Reference decode: field meaning taken straight from the RV32I encoding rules.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int base_op[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int op, f3, f7, x;
    bit ok, r_rd, r_rs1, r_rs2;
    e = '0; e.v = 1'b1;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    ok = 1; r_rd = 0; r_rs1 = 0; r_rs2 = 0; x = 0;
    case (op)
      'h03: begin ok = f3 inside {0, 1, 2, 4, 5}; r_rd = 1; r_rs1 = 1; e.ld = 1;
                  x = int'(w[31:20]); if (x >= 2048) x -= 4096; end
      'h23: begin ok = f3 inside {0, 1, 2}; r_rs1 = 1; r_rs2 = 1; e.st = 1;
                  x = int'(w[31:25]) * 32 + int'(w[11:7]); if (x >= 2048) x -= 4096; end
      'h63: begin ok = f3 inside {0, 1, 4, 5, 6, 7}; r_rs1 = 1; r_rs2 = 1; e.br = 1; e.alu = 1;
                  x = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                  if (w[31]) x -= 8192; end
      'h6F: begin r_rd = 1; e.jp = 1;
                  x = int'(w[31]) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
                  if (w[31]) x -= 2097152; end
      'h67: begin r_rd = 1; r_rs1 = 1; e.jp = 1;
                  x = int'(w[31:20]); if (x >= 2048) x -= 4096; end
      'h37: begin r_rd = 1; e.alu = 10; x = int'(w[31:12]) * 4096; end
      'h17: begin r_rd = 1; x = int'(w[31:12]) * 4096; end
      'h13: begin r_rd = 1; r_rs1 = 1; e.alu = 5'(base_op[f3]);
                  if (f3 == 5 && w[30]) e.alu = 7;
                  x = int'(w[31:20]); if (x >= 2048) x -= 4096; end
      'h33: begin r_rd = 1; r_rs1 = 1; r_rs2 = 1;
              if (f7 == 0) e.alu = 5'(base_op[f3]);
              else if (f7 == 32 && f3 == 0) e.alu = 1;
              else if (f7 == 32 && f3 == 5) e.alu = 7;
`ifdef IDECODE_MEXT_EN
              else if (f7 == 1) e.alu = 5'(16 + f3);
`endif
              else ok = 0;
            end
      default: ok = 0;
    endcase
    if (!ok) begin
      e = '0; e.v = 1'b1; e.ill = 1'b1;
    end else begin
      e.imm = 32'(x);
      e.rd  = r_rd  ? w[11:7]  : 5'd0;
      e.rs1 = r_rs1 ? w[19:15] : 5'd0;
      e.rs2 = r_rs2 ? w[24:20] : 5'd0;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic [6:0] f7; logic [11:0] i12; logic [31:0] r;
    rd = 5'($urandom_range(0, 3)); rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom_range(0, 7)); i12 = 12'($urandom); r = $urandom;
    case ($urandom_range(0, 10))
      0, 9: return {i12, rs1, f3, rd, 7'h03};
      1: return {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23};
      2: return {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h63};
      3: begin
        case ($urandom_range(0, 3))
          0: f7 = 7'h00;
          1: f7 = 7'h20;
          2: f7 = 7'h01;
          default: f7 = 7'($urandom);
        endcase
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      4: return {i12, rs1, f3, rd, 7'h13};
      5: return {r[19:0], rd, 7'h37};
      6: return {r[19:0], rd, 7'h17};
      7: return {r[19:0], rd, 7'h6F};
      8: return {i12, rs1, 3'b000, rd, 7'h67};
      default: return r;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; v_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; inst_i = '0; pc_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  vec_t tbl[$];
  exp_t bub, ill, e_sw, e_lw2, e_srai, e_add, e_lw5, e_mul, e_in, m;
  logic m_v, haz, exp_so, v, st, fl;
  logic [31:0] w;
  logic [15:0] pc, m_pc;

  initial begin
    bub    = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ill    = ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    e_lw2  = ex(1, 2, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    e_add  = ex(1, 3, 2, 2, 0, 0, 0, 0, 0, 0, 0);
    e_sw   = ex(1, 0, 1, 2, 32'd8, 0, 0, 1, 0, 0, 0);
    e_srai = ex(1, 4, 4, 0, 32'h403, 7, 0, 0, 0, 0, 0);
    e_lw5  = ex(1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
`ifdef IDECODE_MEXT_EN
    e_mul  = ex(1, 1, 2, 3, 0, 16, 0, 0, 0, 0, 0);
`else
    e_mul  = ill;
`endif
    tbl.push_back(vc(32'h00500093, 1, 0, 0, 0, ex(1, 1, 0, 0, 32'd5, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(vc(32'h0000A103, 1, 0, 0, 0, e_lw2));
    tbl.push_back(vc(32'h002101B3, 1, 0, 0, 1, bub));
    tbl.push_back(vc(32'h002101B3, 1, 0, 0, 0, e_add));
    tbl.push_back(vc(32'hFE208EE3, 1, 0, 0, 0, ex(1, 0, 1, 2, 32'hFFFFFFFC, 1, 0, 0, 1, 0, 0)));
    tbl.push_back(vc(32'h00500093, 1, 1, 1, 1, bub));
    tbl.push_back(vc(32'hFFFFFFFF, 1, 0, 0, 0, ill));
    tbl.push_back(vc(32'h023100B3, 1, 0, 0, 0, e_mul));
    tbl.push_back(vc(32'h123452B7, 1, 0, 0, 0, ex(1, 5, 0, 0, 32'h12345000, 10, 0, 0, 0, 0, 0)));
    tbl.push_back(vc(32'h0020A423, 1, 0, 0, 0, e_sw));
    tbl.push_back(vc(32'hFF9FF0EF, 1, 0, 0, 0, ex(1, 1, 0, 0, 32'hFFFFFFF8, 0, 0, 0, 0, 1, 0)));
    tbl.push_back(vc(32'h40325213, 1, 0, 0, 0, e_srai));
    tbl.push_back(vc(32'h0000A103, 1, 1, 0, 1, e_srai));
    tbl.push_back(vc(32'h002101B3, 1, 1, 0, 1, e_srai));
    tbl.push_back(vc(32'hFFFFFFFF, 1, 1, 0, 1, e_srai));
    tbl.push_back(vc(32'h00002003, 1, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
    tbl.push_back(vc(32'h00100093, 1, 0, 0, 0, ex(1, 1, 0, 0, 32'd1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(vc(32'h0000A103, 1, 0, 0, 0, e_lw2));
    tbl.push_back(vc(32'h00208093, 1, 0, 0, 0, ex(1, 1, 1, 0, 32'd2, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(vc(32'h0000A103, 1, 0, 0, 0, e_lw2));
    tbl.push_back(vc(32'h0020A423, 1, 0, 0, 1, bub));
    tbl.push_back(vc(32'h0020A423, 1, 0, 0, 0, e_sw));
    tbl.push_back(vc(32'h0000A103, 1, 0, 0, 0, e_lw2));
    tbl.push_back(vc(32'h002101B3, 1, 0, 1, 0, bub));
    tbl.push_back(vc(32'h002101B3, 1, 0, 0, 0, e_add));
    tbl.push_back(vc(32'h00002283, 1, 0, 0, 0, e_lw5));
    tbl.push_back(vc(32'h00128313, 1, 1, 0, 1, e_lw5));
    tbl.push_back(vc(32'h00128313, 1, 0, 0, 1, bub));
    tbl.push_back(vc(32'h00128313, 1, 0, 0, 0, ex(1, 6, 5, 0, 32'd1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(vc(32'h0000A103, 1, 0, 0, 0, e_lw2));
    tbl.push_back(vc(32'h002101B3, 0, 0, 0, 0, bub));

    do_reset();
    #1;
    chk("reset v_o", v_o, 1'b0);
    chk("reset fields", {pc_o, rd_o, rs1_o, rs2_o, alu_op_o}, 0);
    chk("reset imm_o", imm_o, 0);
    chk("reset flags", {is_load_o, is_store_o, is_branch_o, is_jump_o, illegal_o}, 0);
    chk("reset stall_o", stall_o, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      inst_i = tbl[i].inst; v_i = tbl[i].v; stall_i = tbl[i].stall; flush_i = tbl[i].flush;
      pc_i = 16'(i * 4);
      #1 chk($sformatf("tbl[%0d] stall_o", i), stall_o, tbl[i].so);
      @(posedge clk); #1;
      check_out(tbl[i].e, 16'(i * 4), 1'b0, $sformatf("tbl[%0d]", i));
    end

    // Async reset while the hazard bubble is in flight.
    @(negedge clk); inst_i = 32'h0000A103; v_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; pc_i = 16'h0100;
    @(posedge clk);
    @(negedge clk); inst_i = 32'h002101B3; pc_i = 16'h0104;
    #1 chk("bubble stall_o", stall_o, 1'b1);
    @(posedge clk); #1 chk("bubble v_o", v_o, 1'b0);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst mid-bubble v_o", v_o, 1'b0);
    chk("rst mid-bubble stall_o", stall_o, 1'b0);
    chk("rst mid-bubble fields", {pc_o, rd_o, rs1_o, rs2_o, alu_op_o, is_load_o, illegal_o}, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_out(e_add, 16'h0104, 1'b1, "post-reset add");
    #2 rst = 1'b1;
    #1;
    chk("rst async v_o", v_o, 1'b0);
    chk("rst async rd_o", rd_o, 5'd0);
    @(negedge clk) rst = 1'b0;

    // Random stimulus against the reference model.
    m_v = 1'b0; m = '0; m_pc = '0;
    for (int i = 0; i < 600; i++) begin
      w = gen_inst(); pc = 16'($urandom);
      v = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 14) == 0);
      e_in = ref_decode(w);
      haz = m_v && m.ld && (m.rd != 5'd0) && v && ((e_in.rs1 == m.rd) || (e_in.rs2 == m.rd));
      exp_so = st | (haz & ~fl);
      @(negedge clk);
      inst_i = w; v_i = v; stall_i = st; flush_i = fl; pc_i = pc;
      #1 chk($sformatf("rnd[%0d] stall_o inst=%h", i, w), stall_o, exp_so);
      if (fl) m_v = 1'b0;
      else if (st) m_v = m_v;
      else if (haz) m_v = 1'b0;
      else begin m_v = v; m = e_in; m_pc = pc; end
      m.v = m_v;
      @(posedge clk); #1;
      check_out(m, m_pc, 1'b1, $sformatf("rnd[%0d] inst=%h", i, w));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
